// File: rtl/itc_vga_out.sv
// ITC clocked-video to VGA DAC output stage: two-stage registered pipeline with
// sync polarity control, geometry/frame measurement, underflow monitor and colour bars.
module itc_vga_out #(
   parameter bit H_SYNC_POL     = 1'b0,
   parameter bit V_SYNC_POL     = 1'b0,
   parameter int BAR_WIDTH      = 80,
   parameter int CNT_W          = 12,
   parameter bit BLANK_ON_UFLOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [23:0]      vid_data,
   input  logic             vid_datavalid,
   input  logic             vid_h_sync,
   input  logic             vid_v_sync,
   input  logic             vid_underflow,
   input  logic             pattern_en,
   input  logic             clr_status,
   output logic [7:0]       vga_r,
   output logic [7:0]       vga_g,
   output logic [7:0]       vga_b,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_blank_n,
   output logic [15:0]      frame_count,
   output logic [CNT_W-1:0] meas_width,
   output logic [CNT_W-1:0] meas_height,
   output logic             underflow_sticky
);

   localparam int              BW_W     = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
   localparam logic [BW_W-1:0] BAR_LAST = BW_W'(BAR_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [23:0]      s1_data;
   logic             s1_dv, s1_hs, s1_vs, s1_uf;
   logic             s1_dv_prev, s1_vs_prev;
   logic [CNT_W-1:0] px_cnt, ln_cnt;
   logic [BW_W-1:0]  bar_px;
   logic [2:0]       bar_idx;
   logic             pat_active, frame_err;

   logic             fs, dv_fall, pat_nxt, err_nxt;
   logic [23:0]      colour, rgb_nxt;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Stage 1: register inputs; the *_prev flops hold the previous S1 levels for edge detection.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_data    <= '0;
         s1_dv      <= 1'b0;
         s1_hs      <= 1'b0;
         s1_vs      <= 1'b0;
         s1_uf      <= 1'b0;
         s1_dv_prev <= 1'b0;
         s1_vs_prev <= 1'b0;
      end else begin
         s1_data    <= vid_data;
         s1_dv      <= vid_datavalid;
         s1_hs      <= vid_h_sync;
         s1_vs      <= vid_v_sync;
         s1_uf      <= vid_underflow;
         s1_dv_prev <= s1_dv;
         s1_vs_prev <= s1_vs;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      fs      = s1_vs & ~s1_vs_prev;
      dv_fall = ~s1_dv & s1_dv_prev;
      pat_nxt = fs ? pattern_en : pat_active;
      // Underflow outranks the frame-start clear, and blanks the offending pixel itself.
      err_nxt = s1_uf | (frame_err & ~fs);
      colour  = s1_data;
      if (err_nxt && BLANK_ON_UFLOW) colour = 24'h000000;
      else if (pat_nxt)              colour = bar_colour(bar_idx);
      rgb_nxt = s1_dv ? colour : 24'h000000;
   end

   // Stage 2: outputs, frame state and measurement counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {vga_r, vga_g, vga_b} <= '0;
         vga_blank_n <= 1'b0;
         vga_hs      <= ~H_SYNC_POL;
         vga_vs      <= ~V_SYNC_POL;
         pat_active  <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         px_cnt      <= '0;
         ln_cnt      <= '0;
         meas_width  <= '0;
         meas_height <= '0;
         bar_px      <= '0;
         bar_idx     <= '0;
      end else begin
         {vga_r, vga_g, vga_b} <= rgb_nxt;
         vga_blank_n <= s1_dv;
         vga_hs      <= H_SYNC_POL ? s1_hs : ~s1_hs;
         vga_vs      <= V_SYNC_POL ? s1_vs : ~s1_vs;
         pat_active  <= pat_nxt;
         frame_err   <= err_nxt;

         if (fs) frame_count <= frame_count + 16'd1;

         if (!s1_dv)                px_cnt <= '0;
         else if (px_cnt != CNT_MAX) px_cnt <= px_cnt + 1'b1;

         if (dv_fall) meas_width <= px_cnt;

         if (fs) begin
            meas_height <= ln_cnt;
            ln_cnt      <= '0;
         end else if (dv_fall && ln_cnt != CNT_MAX) begin
            ln_cnt <= ln_cnt + 1'b1;
         end

         if (!s1_dv) begin
            bar_px  <= '0;
            bar_idx <= '0;
         end else if (bar_px == BAR_LAST) begin
            bar_px <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_px <= bar_px + 1'b1;
         end
      end
   end

   // Set wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          underflow_sticky <= 1'b0;
      else if (vid_underflow) underflow_sticky <= 1'b1;
      else if (clr_status)    underflow_sticky <= 1'b0;
   end

endmodule

// File: doc/itc_vga_out.md
Name: itc_vga_out

Overview:
- Downstream stage of the ITC clocked-video output (24-bit RGB, datavalid, h/v sync, underflow), running in the VGA pixel clock domain.
- Converts the clocked-video stream into registered VGA DAC signals: R/G/B, HS, VS and BLANK_N, with programmable sync polarity.
- Adds frame and geometry measurement, a sticky underflow monitor, and a colour-bar test pattern substituted per frame for camera/frame-buffer bring-up.

Parameters:
- H_SYNC_POL, 0, output HS active level (0 = active-low, 1 = active-high).
- V_SYNC_POL, 0, output VS active level.
- BAR_WIDTH, 80, pixels per colour bar (>=1).
- CNT_W, 12, width of the pixel, line and geometry counters.
- BLANK_ON_UFLOW, 1, when 1, force black for the remainder of any frame in which underflow occurred.

Ports:
- clk  in  1  pixel clock (same clock as the ITC vid_clk).
- reset_n  in  1  asynchronous active-low reset.
- vid_data  in  24  {R[23:16],G[15:8],B[7:0]} from ITC.
- vid_datavalid  in  1  active pixel qualifier.
- vid_h_sync  in  1  horizontal sync, active-high.
- vid_v_sync  in  1  vertical sync, active-high.
- vid_underflow  in  1  ITC FIFO underflow pulse.
- pattern_en  in  1  request colour bars, sampled at frame start.
- clr_status  in  1  single-cycle clear of underflow_sticky.
- vga_r / vga_g / vga_b  out  8 each  DAC colour.
- vga_hs / vga_vs  out  1  syncs at the configured polarity.
- vga_blank_n  out  1  0 during blanking.
- frame_count  out  16  frames seen; wraps from 0xFFFF to 0.
- meas_width  out  CNT_W  active pixels in the last completed line.
- meas_height  out  CNT_W  active lines in the last completed frame.
- underflow_sticky  out  1  underflow seen since the last clear.

Behaviour:
- Reset (async assert, sync release):
  - RGB = 0, vga_blank_n = 0.
  - vga_hs = ~H_SYNC_POL, vga_vs = ~V_SYNC_POL (inactive levels).
  - All counters, frame_count, meas_* and underflow_sticky = 0; pattern and error state cleared.
- Pipeline: two register stages, fixed latency of 2 clocks from input to every VGA output, so syncs, blank and colour stay aligned.
  - S1 registers the inputs and the previous v_sync/datavalid levels.
  - S2 selects colour and drives the outputs.
- Output mapping:
  - vga_hs = H_SYNC_POL ? h_sync : ~h_sync; vga_vs likewise with V_SYNC_POL.
  - vga_blank_n = datavalid delayed 2 clocks; RGB = 0 whenever blank_n is 0.
- Frame start (FS) = rising edge of vid_v_sync (S1 level 1, previous level 0). On FS:
  - frame_count += 1.
  - meas_height <= ln_cnt, then ln_cnt <= 0.
  - pat_active <= pattern_en.
  - frame_err <= 0.
- Line counting:
  - px_cnt increments on each datavalid cycle and is held at 0 while datavalid = 0.
  - On a datavalid falling edge: meas_width <= px_cnt and ln_cnt += 1.
  - px_cnt and ln_cnt saturate at 2^CNT_W-1 (no wrap).
- Colour bars:
  - bar_px counts 0..BAR_WIDTH-1 during datavalid; on terminal count it returns to 0 and bar_idx increments, saturating at 7.
  - bar_px and bar_idx reset to 0 while datavalid = 0. No divider.
  - bar_idx 0..7 = white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Colour select: if frame_err and BLANK_ON_UFLOW → 000000; else if pat_active → bar colour; else vid_data.
- Underflow:
  - vid_underflow = 1 sets underflow_sticky and frame_err.
  - clr_status clears underflow_sticky only; set wins when both occur in the same cycle.
  - Underflow on the FS cycle: frame_err = 1 for the new frame (set wins over FS clear).
- pattern_en changes mid-frame have no effect until the next FS.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the first FS starts normal operation; meas_height from that first FS reflects a partial frame and is valid from the second FS onward.

Test Plan:
- Reset, then idle (datavalid = 0, syncs 0), params default → vga_hs = 1, vga_vs = 1, blank_n = 0, RGB = 0, frame_count = 0.
- 16x4 active frames, vid_data = 123456, two frames → each active pixel appears 2 clocks later as R=12, G=34, B=56; meas_width = 16, meas_height = 4 after the 2nd FS; frame_count = 2.
- BAR_WIDTH = 2, pattern_en = 1 before FS, 16-pixel line → outputs FFFFFF ×2, FFFF00 ×2, … 000000 ×2; pattern_en dropped mid-frame → bars persist until next FS.
- Underflow pulse at pixel 5 of line 2 → underflow_sticky = 1; RGB = 0 for the rest of that frame; normal data at the next frame; sticky stays 1 until clr_status pulse. clr_status and underflow in the same cycle → sticky remains 1.
- H_SYNC_POL = 1, V_SYNC_POL = 1 → vga_hs/vga_vs equal the input syncs delayed 2 clocks, reset value 0.
- 0xFFFF frames (force or preload) → next FS wraps frame_count to 0; reset asserted mid-line → all outputs at reset values in the same cycle.
